// File: rtl/fetch_stage.sv
// Instruction-fetch stage that sits directly in front of a combinational instruction memory.
// It owns the fetch PC, drives the memory address and captures each returned word into a
// small circular queue. Decode takes entries {pc, instr, fault} over a valid/ready handshake.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   imem_pc        byte address to instruction memory (the current fetch PC)
//   imem_instr     word returned combinationally for imem_pc
//   redirect_valid branch/jump taken: flush the queue and restart at redirect_pc
//   redirect_pc    new fetch address
//   out_valid      queue head valid
//   out_ready      decode accepts the head this cycle
//   out_pc         PC of the head entry (0 when empty)
//   out_instr      instruction of the head entry (0 when empty)
//   out_fault      head entry is a misaligned or out-of-range fetch (0 when empty)
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned MEM_BYTES   = 4096,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam int unsigned PtrW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [31:0] LastPc = 32'(MEM_BYTES - 4);
  localparam logic [CntW-1:0] Depth = CntW'(QUEUE_DEPTH);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;

  logic [31:0] pc_mem_q    [QUEUE_DEPTH];
  logic [31:0] instr_mem_q [QUEUE_DEPTH];
  logic        fault_mem_q [QUEUE_DEPTH];

  logic fetch_fault;
  logic push;
  logic pop;

  assign imem_pc     = fetch_pc_q;
  assign fetch_fault = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q > LastPc);

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // Pushing into a full queue is fine when the head leaves in the same cycle.
  assign push      = (state_q == StRun) & ~redirect_valid & ((count_q < Depth) | pop);

  // Empty queue drives zeros so stale entries never leak onto the outputs.
  assign out_pc    = out_valid ? pc_mem_q[rptr_q]    : '0;
  assign out_instr = out_valid ? instr_mem_q[rptr_q] : '0;
  assign out_fault = out_valid ? fault_mem_q[rptr_q] : 1'b0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;

    if (redirect_valid) begin
      // A same-cycle pop is dropped along with the rest of the queue.
      state_d    = StRun;
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rptr_d     = '0;
      wptr_d     = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + 1'b1;
        if (fetch_fault) begin
          // Park on the faulting address until a redirect arrives.
          state_d = StHalt;
        end else begin
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
    end
  end

  // Entry storage needs no reset: the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q]    <= fetch_pc_q;
      instr_mem_q[wptr_q] <= fetch_fault ? NOP_INSTR : imem_instr;
      fault_mem_q[wptr_q] <= fetch_fault;
    end
  end

endmodule
